bus_arbiter_2: RTL
==================

BUS_ARBITER_2 -- requirements
Module: bus_arbiter_2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles a granted transfer may wait for device ready before forced completion.
REQ-002 SHALL have parameter ERR_RDATA, default 32'h0000_0000: read data returned on a timed-out transfer.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports h0_address, h1_address  input  32  requester byte addresses.
REQ-006 SHALL have ports h0_data_write, h1_data_write  input  32  requester write data.
REQ-007 SHALL have ports h0_write_mask, h1_write_mask  input  4  requester byte-lane enables.
REQ-008 SHALL have ports h0_ren/h0_wen, h1_ren/h1_wen  input  1 each  requester read/write strobes, held until that requester's ready.
REQ-009 SHALL have ports h0_data_read, h1_data_read  output  32  read data to requester.
REQ-010 SHALL have ports h0_ready, h1_ready  output  1  single-cycle completion pulse per requester.
REQ-011 SHALL have ports dev_address, dev_data_write, dev_write_mask, dev_ren, dev_wen  output  32/32/4/1/1  shared downstream port (bus_hub host side).
REQ-012 SHALL have ports dev_data_read  input  32, dev_ready  input  1  downstream response.
REQ-013 SHALL have port grant  output  2  one-hot current owner (bit0=h0, bit1=h1), 0 when idle.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse when a transfer is forced complete by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT0, GRANT1, state held in a register.
REQ-016 In IDLE, a requester SHALL be requesting when its ren|wen is high; no request keeps IDLE.
REQ-017 In IDLE with exactly one requester, SHALL enter that requester's GRANT state next cycle.
REQ-018 In IDLE with both requesting, SHALL grant the requester not served last (last_owner register; after reset h0 wins first tie).
REQ-019 In GRANTn, dev_address/data_write/write_mask/ren/wen SHALL equal requester n's inputs combinationally; in IDLE dev_ren=dev_wen=0, other dev outputs 0.
REQ-020 In GRANTn, hn_data_read SHALL equal dev_data_read and hn_ready SHALL equal dev_ready combinationally; the non-owner's ready SHALL be 0 and data_read 0.
REQ-021 On dev_ready high in GRANTn, SHALL return to IDLE next cycle and set last_owner=n.
REQ-022 Minimum transfer: request sampled in IDLE at cycle N, dev strobe at N+1, ready earliest N+1 (zero-wait device) or N+2 (registered device); one idle cycle between back-to-back grants.
REQ-023 A wait counter SHALL clear on entering GRANTn and increment each GRANT cycle without dev_ready.
REQ-024 When counter reaches TIMEOUT_CYCLES without dev_ready, SHALL pulse hn_ready with hn_data_read=ERR_RDATA, pulse timeout_err, drop dev strobes that cycle, go IDLE, set last_owner=n.
REQ-025 dev_ready and timeout in the same cycle SHALL count as normal completion (real data, no timeout_err).
REQ-026 If owner drops ren/wen mid-grant (protocol violation), SHALL stay in GRANTn until ready or timeout; no spurious grant to other requester.
REQ-027 grant SHALL reflect state registers only (no combinational path from inputs).

Reset
REQ-028 On rst high at a clock edge SHALL force IDLE, last_owner=h1 (so h0 wins first tie), counter=0; all outputs 0 in the following cycle, including mid-transfer.
REQ-029 An in-flight transfer aborted by reset SHALL produce no ready pulse.

Structure
REQ-030 State enum (IDLE/GRANT0/GRANT1) and ERR_RDATA default SHALL live in shared package bus_pkg alongside bus_hub constants.
REQ-031 No sub-modules; single flat module with one sequential and one combinational process.

Verification
REQ-032 h0 read 0x100 alone, device ready 1 cycle later with 0xCAFEF00D -> grant=01, h0_ready one pulse, h0_data_read=0xCAFEF00D, h1_ready=0.
REQ-033 h0 and h1 both request from reset -> h0 served first, then h1; repeat both held -> strict alternation h0,h1,h0,h1.
REQ-034 h1 write 0x2000 data 0x12345678 mask 4'b0011 -> dev_* match exactly during GRANT1, dev_wen=0 in IDLE.
REQ-035 Device never ready, TIMEOUT_CYCLES=8 -> h0_ready and timeout_err pulse 8 cycles after grant, h0_data_read=ERR_RDATA, arbiter then serves pending h1.
REQ-036 rst asserted during GRANT1 wait -> next cycle grant=0, dev_ren=0, no h1_ready pulse; h0 wins subsequent tie.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus_hub definitions: port widths, default error read data and the
// two-requester arbiter state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = BUS_DATA_W / 8;

  localparam logic [BUS_DATA_W-1:0] BUS_ERR_RDATA = 32'h0000_0000;

  // Grant states are one-hot so the grant output is the state register itself.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT0 = 2'b01,
    ARB_GRANT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_2.sv
// Two-requester round-robin arbiter onto one bus_hub host port, with a
// per-transfer wait timeout that forces completion with error read data.
module bus_arbiter_2
  import bus_pkg::*;
#(
  parameter int unsigned                 TIMEOUT_CYCLES = 255,
  parameter logic [BUS_DATA_W-1:0]       ERR_RDATA      = BUS_ERR_RDATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_ADDR_W-1:0] h0_address,
  input  logic [BUS_ADDR_W-1:0] h1_address,
  input  logic [BUS_DATA_W-1:0] h0_data_write,
  input  logic [BUS_DATA_W-1:0] h1_data_write,
  input  logic [BUS_MASK_W-1:0] h0_write_mask,
  input  logic [BUS_MASK_W-1:0] h1_write_mask,
  input  logic                  h0_ren,
  input  logic                  h0_wen,
  input  logic                  h1_ren,
  input  logic                  h1_wen,
  output logic [BUS_DATA_W-1:0] h0_data_read,
  output logic [BUS_DATA_W-1:0] h1_data_read,
  output logic                  h0_ready,
  output logic                  h1_ready,
  output logic [BUS_ADDR_W-1:0] dev_address,
  output logic [BUS_DATA_W-1:0] dev_data_write,
  output logic [BUS_MASK_W-1:0] dev_write_mask,
  output logic                  dev_ren,
  output logic                  dev_wen,
  input  logic [BUS_DATA_W-1:0] dev_data_read,
  input  logic                  dev_ready,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_last_owner;      // 1'b0 = h0 served last, 1'b1 = h1
  logic             w_last_owner_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;

  logic             w_req0;
  logic             w_req1;
  logic             w_owner1;
  logic             w_timeout;
  logic             w_done;
  logic [BUS_DATA_W-1:0] w_rdata;

  assign w_req0   = h0_ren | h0_wen;
  assign w_req1   = h1_ren | h1_wen;
  assign w_owner1 = (r_state == ARB_GRANT1);
  assign grant    = r_state;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= 1'b1;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_timeout        = 1'b0;
    w_done           = 1'b0;
    w_rdata          = '0;
    dev_address      = '0;
    dev_data_write   = '0;
    dev_write_mask   = '0;
    dev_ren          = 1'b0;
    dev_wen          = 1'b0;
    h0_data_read     = '0;
    h1_data_read     = '0;
    h0_ready         = 1'b0;
    h1_ready         = 1'b0;
    timeout_err      = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        w_wait_cnt_nxt = '0;
        // On a tie the requester that was not served last wins.
        if (w_req0 && (!w_req1 || r_last_owner)) begin
          w_state_nxt = ARB_GRANT0;
        end else if (w_req1) begin
          w_state_nxt = ARB_GRANT1;
        end
      end

      ARB_GRANT0, ARB_GRANT1: begin
        // A device ready in the timeout cycle still wins: real data, no error.
        w_timeout      = !dev_ready && (r_wait_cnt == CNT_LIMIT);
        w_done         = dev_ready | w_timeout;
        w_rdata        = w_timeout ? ERR_RDATA : dev_data_read;
        timeout_err    = w_timeout;

        dev_address    = w_owner1 ? h1_address    : h0_address;
        dev_data_write = w_owner1 ? h1_data_write : h0_data_write;
        dev_write_mask = w_owner1 ? h1_write_mask : h0_write_mask;
        dev_ren        = (w_owner1 ? h1_ren : h0_ren) & ~w_timeout;
        dev_wen        = (w_owner1 ? h1_wen : h0_wen) & ~w_timeout;

        if (w_owner1) begin
          h1_data_read = w_rdata;
          h1_ready     = w_done;
        end else begin
          h0_data_read = w_rdata;
          h0_ready     = w_done;
        end

        if (w_done) begin
          w_state_nxt      = ARB_IDLE;
          w_last_owner_nxt = w_owner1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = ARB_IDLE;
    endcase
  end

endmodule
